hazard_scoreboard_unit: RTL and testbench

//  Next-gen pipeline hazard unit for the in-order RISC-V core; sits beside ID and drives all stage enables/flushes.

---
 rtl/hazard_scoreboard_unit.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_unit.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_unit
//
// Pipeline hazard unit for the in-order RISC-V core. It sits beside ID and
// drives every stage enable and flush. In-flight register writers are kept in
// a DEPTH-entry shift pipe (entry0 = EXE, entry1 = MEM, ...). From that pipe
// the unit derives load-use and multi-cycle stalls, per-source forwarding
// selects, taken-branch flushes lasting FLUSH_CYC cycles, a global freeze on
// data-memory wait, and a saturating count of cycles in which the PC stalled.
//
// Optional feature macro: HDU_LS_FWD_EN
//   When defined, a store whose data register (rs2) is produced by a load
//   sitting in EXE issues without stalling, and fwd_ls_o tells EXE to take
//   the store data from the MEM-stage load result on the following cycle.
//   When undefined, that case stalls like any load-use and fwd_ls_o is 0.
//
// Ports
//   clk, rst_n                core clock (rising edge), async active-low reset
//   id_valid_i                valid instruction in ID
//   rs1use_i, rs2use_i        ID reads rs1 / rs2
//   rs1_i, rs2_i              ID source registers
//   rd_i, rd_we_i             ID destination register and its write enable
//   optype_i                  00 none, 01 ALU, 10 LOAD, 11 BRANCH
//   is_mul_i                  ID op is MUL class (late result)
//   store_i                   ID op is a store (rs2 is store data only)
//   branch_taken_i            branch in EXE resolved taken
//   mem_stall_i               data memory not ready, freeze the whole pipe
//   pc_en_o .. mw_en_o        stage enables
//   fd_flush_o, de_flush_o    bubble into IF/ID, ID/EX
//   fwd_a_o, fwd_b_o          0 = regfile, k = forward from entry k-1
//   fwd_ls_o                  EXE store data from MEM-stage load result
//   stall_cnt_o               saturating count of cycles with pc_en_o = 0
// ---------------------------------------------------------------------------
module hazard_scoreboard_unit #(
    parameter int DEPTH     = 3,
    parameter int MUL_LAT   = 2,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           id_valid_i,
    input  logic                           rs1use_i,
    input  logic                           rs2use_i,
    input  logic [4:0]                     rs1_i,
    input  logic [4:0]                     rs2_i,
    input  logic [4:0]                     rd_i,
    input  logic                           rd_we_i,
    input  logic [1:0]                     optype_i,
    input  logic                           is_mul_i,
    input  logic                           store_i,
    input  logic                           branch_taken_i,
    input  logic                           mem_stall_i,
    output logic                           pc_en_o,
    output logic                           fd_en_o,
    output logic                           de_en_o,
    output logic                           em_en_o,
    output logic                           mw_en_o,
    output logic                           fd_flush_o,
    output logic                           de_flush_o,
    output logic [$clog2(DEPTH+1)-1:0]     fwd_a_o,
    output logic [$clog2(DEPTH+1)-1:0]     fwd_b_o,
    output logic                           fwd_ls_o,
    output logic [CNT_W-1:0]               stall_cnt_o
);

    localparam int FSW = $clog2(DEPTH+1);
    localparam int FCW = 2;

    typedef enum logic [1:0] {
        OP_NONE   = 2'b00,
        OP_ALU    = 2'b01,
        OP_LOAD   = 2'b10,
        OP_BRANCH = 2'b11
    } optype_e;

    // Writer pipe: entry k holds the instruction k+1 stages ahead of ID.
    // rdy is the lowest entry index from which the result can be forwarded.
    logic [DEPTH-1:0] entValid_q, entValid_d;
    logic [DEPTH-1:0] entLoad_q,  entLoad_d;
    logic [4:0]       entRd_q  [DEPTH];
    logic [4:0]       entRd_d  [DEPTH];
    logic [FSW-1:0]   entRdy_q [DEPTH];
    logic [FSW-1:0]   entRdy_d [DEPTH];

    logic [FCW-1:0]   fcnt_q, fcnt_d;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

    logic             matchA, matchB;
    logic [FSW-1:0]   idxA, idxB;
    logic [FSW-1:0]   rdyA, rdyB;
    logic             hazA, hazB;
    logic [FSW-1:0]   fwdA, fwdB;
    logic             lsPath;
    logic             dataStall;
    logic             flushNow;

    logic             issueValid;
    logic [FSW-1:0]   issueRdy;
    logic             issueLoad;

    logic             shiftEn;
    logic             insertBubble;

    // Search from the oldest entry down to entry0 so the youngest writer of
    // a register is the one left standing. x0 and unused sources never match.
    always_comb begin
        matchA = 1'b0;
        idxA   = '0;
        rdyA   = '0;
        matchB = 1'b0;
        idxB   = '0;
        rdyB   = '0;
        for (int k = DEPTH-1; k >= 0; k--) begin
            if (entValid_q[k] && (entRd_q[k] == rs1_i)) begin
                matchA = 1'b1;
                idxA   = FSW'(k);
                rdyA   = entRdy_q[k];
            end
            if (entValid_q[k] && (entRd_q[k] == rs2_i)) begin
                matchB = 1'b1;
                idxB   = FSW'(k);
                rdyB   = entRdy_q[k];
            end
        end
        if (!rs1use_i || (rs1_i == 5'd0)) begin
            matchA = 1'b0;
        end
        if (!rs2use_i || (rs2_i == 5'd0)) begin
            matchB = 1'b0;
        end
    end

    // A match hazards when the producer has not yet reached the stage where
    // its result becomes forwardable; otherwise forward from that entry.
    assign hazA = matchA && (idxA < rdyA);
    assign hazB = matchB && (idxB < rdyB);
    assign fwdA = matchA ? (idxA + FSW'(1)) : '0;
    assign fwdB = matchB ? (idxB + FSW'(1)) : '0;

`ifdef HDU_LS_FWD_EN
    // Store data produced by a load in EXE can be picked up one cycle later
    // from the MEM-stage load result, so the store need not wait for it.
    assign lsPath = id_valid_i && store_i && hazB && (idxB == '0) &&
                    entLoad_q[0] && !hazA;
`else
    assign lsPath = 1'b0;
    logic unusedLsInputs;
    assign unusedLsInputs = ^{store_i, entLoad_q};
`endif

    assign dataStall = id_valid_i && (hazA || (hazB && !lsPath));
    assign flushNow  = branch_taken_i || (fcnt_q != '0);

    assign fwd_a_o = fwdA;
    assign fwd_b_o = lsPath ? '0 : fwdB;

    // Only ALU (including MUL) and LOAD ops that really write a non-zero rd
    // become tracked writers; everything else enters the pipe as a bubble.
    always_comb begin
        issueValid = id_valid_i && rd_we_i && (rd_i != 5'd0) &&
                     ((optype_i == OP_ALU) || (optype_i == OP_LOAD));
        issueLoad  = (optype_i == OP_LOAD);
        if (optype_i == OP_LOAD) begin
            issueRdy = FSW'(1);
        end else if (is_mul_i) begin
            issueRdy = FSW'(MUL_LAT-1);
        end else begin
            issueRdy = '0;
        end
    end

    // Per-cycle control with priority mem freeze > branch flush > data stall
    // > normal issue. While rst_n is low the outputs are forced to their
    // idle values so they follow reset without waiting for a clock.
    always_comb begin
        pc_en_o      = 1'b1;
        fd_en_o      = 1'b1;
        de_en_o      = 1'b1;
        em_en_o      = 1'b1;
        mw_en_o      = 1'b1;
        fd_flush_o   = 1'b0;
        de_flush_o   = 1'b0;
        shiftEn      = 1'b1;
        insertBubble = 1'b0;
        fcnt_d       = fcnt_q;
        if (mem_stall_i) begin
            pc_en_o = 1'b0;
            fd_en_o = 1'b0;
            de_en_o = 1'b0;
            em_en_o = 1'b0;
            mw_en_o = 1'b0;
            shiftEn = 1'b0;
        end else if (flushNow) begin
            fd_flush_o   = 1'b1;
            de_flush_o   = 1'b1;
            insertBubble = 1'b1;
            if (branch_taken_i) begin
                fcnt_d = FCW'(FLUSH_CYC-1);
            end else begin
                fcnt_d = fcnt_q - FCW'(1);
            end
        end else if (dataStall) begin
            pc_en_o      = 1'b0;
            fd_en_o      = 1'b0;
            de_flush_o   = 1'b1;
            insertBubble = 1'b1;
        end
        if (!rst_n) begin
            pc_en_o    = 1'b1;
            fd_en_o    = 1'b1;
            de_en_o    = 1'b1;
            em_en_o    = 1'b1;
            mw_en_o    = 1'b1;
            fd_flush_o = 1'b0;
            de_flush_o = 1'b0;
        end
    end

    // Shift the writer pipe one stage; entry0 takes the ID instruction or a
    // bubble, and the oldest entry falls off the end.
    always_comb begin
        entValid_d = entValid_q;
        entLoad_d  = entLoad_q;
        for (int k = 0; k < DEPTH; k++) begin
            entRd_d[k]  = entRd_q[k];
            entRdy_d[k] = entRdy_q[k];
        end
        if (shiftEn) begin
            for (int k = DEPTH-1; k >= 1; k--) begin
                entValid_d[k] = entValid_q[k-1];
                entLoad_d[k]  = entLoad_q[k-1];
                entRd_d[k]    = entRd_q[k-1];
                entRdy_d[k]   = entRdy_q[k-1];
            end
            entValid_d[0] = insertBubble ? 1'b0 : issueValid;
            entLoad_d[0]  = insertBubble ? 1'b0 : issueLoad;
            entRd_d[0]    = insertBubble ? 5'd0 : rd_i;
            entRdy_d[0]   = insertBubble ? '0   : issueRdy;
        end
    end

    // Counts every PC-stalled cycle and sticks at all-ones.
    always_comb begin
        stallCnt_d = stallCnt_q;
        if (!pc_en_o && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entValid_q <= '0;
            entLoad_q  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                entRd_q[k]  <= 5'd0;
                entRdy_q[k] <= '0;
            end
            fcnt_q     <= '0;
            stallCnt_q <= '0;
        end else begin
            entValid_q <= entValid_d;
            entLoad_q  <= entLoad_d;
            for (int k = 0; k < DEPTH; k++) begin
                entRd_q[k]  <= entRd_d[k];
                entRdy_q[k] <= entRdy_d[k];
            end
            fcnt_q     <= fcnt_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    assign stall_cnt_o = stallCnt_q;

`ifdef HDU_LS_FWD_EN
    logic fwdLs_q, fwdLs_d;

    // Pulses for the one cycle in which the forwarded store sits in EXE;
    // it holds through a memory freeze and is dropped by a flush.
    always_comb begin
        fwdLs_d = lsPath;
        if (mem_stall_i) begin
            fwdLs_d = fwdLs_q;
        end else if (flushNow) begin
            fwdLs_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwdLs_q <= 1'b0;
        end else begin
            fwdLs_q <= fwdLs_d;
        end
    end

    assign fwd_ls_o = fwdLs_q;
`else
    assign fwd_ls_o = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard_unit
//
// Directed bench for hazard_scoreboard_unit built with DEPTH=3, MUL_LAT=3,
// FLUSH_CYC=2 and a 4-bit stall counter so saturation is reachable quickly.
// Each step drives ID/control inputs, then compares outputs against
// hand-derived values between clock edges.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard_unit;

   localparam int DEPTH     = 3;
   localparam int MUL_LAT   = 3;
   localparam int FLUSH_CYC = 2;
   localparam int CNT_W     = 4;
   localparam int FSW       = $clog2(DEPTH+1);

   localparam int OP_NONE = 0;
   localparam int OP_ALU  = 1;
   localparam int OP_LOAD = 2;

   logic             clk;
   logic             rst_n;
   logic             id_valid_i;
   logic             rs1use_i;
   logic             rs2use_i;
   logic [4:0]       rs1_i;
   logic [4:0]       rs2_i;
   logic [4:0]       rd_i;
   logic             rd_we_i;
   logic [1:0]       optype_i;
   logic             is_mul_i;
   logic             store_i;
   logic             branch_taken_i;
   logic             mem_stall_i;
   logic             pc_en_o;
   logic             fd_en_o;
   logic             de_en_o;
   logic             em_en_o;
   logic             mw_en_o;
   logic             fd_flush_o;
   logic             de_flush_o;
   logic [FSW-1:0]   fwd_a_o;
   logic [FSW-1:0]   fwd_b_o;
   logic             fwd_ls_o;
   logic [CNT_W-1:0] stall_cnt_o;

   int vectors     = 0;
   int miscompares = 0;

   hazard_scoreboard_unit #(
      .DEPTH     (DEPTH),
      .MUL_LAT   (MUL_LAT),
      .FLUSH_CYC (FLUSH_CYC),
      .CNT_W     (CNT_W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .id_valid_i     (id_valid_i),
      .rs1use_i       (rs1use_i),
      .rs2use_i       (rs2use_i),
      .rs1_i          (rs1_i),
      .rs2_i          (rs2_i),
      .rd_i           (rd_i),
      .rd_we_i        (rd_we_i),
      .optype_i       (optype_i),
      .is_mul_i       (is_mul_i),
      .store_i        (store_i),
      .branch_taken_i (branch_taken_i),
      .mem_stall_i    (mem_stall_i),
      .pc_en_o        (pc_en_o),
      .fd_en_o        (fd_en_o),
      .de_en_o        (de_en_o),
      .em_en_o        (em_en_o),
      .mw_en_o        (mw_en_o),
      .fd_flush_o     (fd_flush_o),
      .de_flush_o     (de_flush_o),
      .fwd_a_o        (fwd_a_o),
      .fwd_b_o        (fwd_b_o),
      .fwd_ls_o       (fwd_ls_o),
      .stall_cnt_o    (stall_cnt_o)
   );

   // Free-running 10-time-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one ID instruction plus the branch/memory controls, then lets
   // the combinational outputs settle.
   task automatic applyStimulus(input int valid, input int r1use, input int r1,
                                input int r2use, input int r2, input int rdwe,
                                input int rd, input int op, input int mul,
                                input int st, input int bt, input int ms);
      id_valid_i     = 1'(valid);
      rs1use_i       = 1'(r1use);
      rs1_i          = 5'(r1);
      rs2use_i       = 1'(r2use);
      rs2_i          = 5'(r2);
      rd_we_i        = 1'(rdwe);
      rd_i           = 5'(rd);
      optype_i       = 2'(op);
      is_mul_i       = 1'(mul);
      store_i        = 1'(st);
      branch_taken_i = 1'(bt);
      mem_stall_i    = 1'(ms);
      #1;
   endtask

   // One comparison: counts it, and on a miscompare reports tag and values.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Advance past the next rising edge and settle 1 unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, OP_NONE, 0, 0, 0, 0);
      #11;
      checkOutput("rst_pc_en",     32'(pc_en_o),     32'd1);
      checkOutput("rst_mw_en",     32'(mw_en_o),     32'd1);
      checkOutput("rst_de_flush",  32'(de_flush_o),  32'd0);
      checkOutput("rst_fwd_a",     32'(fwd_a_o),     32'd0);
      checkOutput("rst_fwd_ls",    32'(fwd_ls_o),    32'd0);
      checkOutput("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
      rst_n = 1'b1;
      tick();

      // ALU x5 then ADD rs1=x5 forwards from EXE; one bubble later from MEM.
      applyStimulus(1, 0, 0, 0, 0, 1, 5, OP_ALU, 0, 0, 0, 0);
      checkOutput("alu_issue_pc_en", 32'(pc_en_o), 32'd1);
      tick();
      applyStimulus(1, 1, 5, 0, 0, 1, 10, OP_ALU, 0, 0, 0, 0);
      checkOutput("alu_fwd_a_exe", 32'(fwd_a_o), 32'd1);
      checkOutput("alu_fwd_pc_en", 32'(pc_en_o), 32'd1);
      tick();
      applyStimulus(1, 0, 0, 0, 0, 1, 11, OP_ALU, 0, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, OP_NONE, 0, 0, 0, 0);
      tick();
      applyStimulus(1, 1, 11, 0, 0, 0, 0, OP_ALU, 0, 0, 0, 0);
      checkOutput("alu_fwd_a_mem", 32'(fwd_a_o), 32'd2);
      tick();

      // LW x6 then ADD rs2=x6: one stall cycle, then forward from MEM.
      applyStimulus(1, 0, 0, 0, 0, 1, 6, OP_LOAD, 0, 0, 0, 0);
      tick();
      applyStimulus(1, 0, 0, 1, 6, 1, 12, OP_ALU, 0, 0, 0, 0);
      checkOutput("lu_pc_en",    32'(pc_en_o),    32'd0);
      checkOutput("lu_fd_en",    32'(fd_en_o),    32'd0);
      checkOutput("lu_de_en",    32'(de_en_o),    32'd1);
      checkOutput("lu_de_flush", 32'(de_flush_o), 32'd1);
      checkOutput("lu_fd_flush", 32'(fd_flush_o), 32'd0);
      tick();
      checkOutput("lu_resume_pc_en", 32'(pc_en_o),     32'd1);
      checkOutput("lu_fwd_b",        32'(fwd_b_o),     32'd2);
      checkOutput("lu_stall_cnt",    32'(stall_cnt_o), 32'd1);
      tick();

      // MUL x7 with MUL_LAT=3: two stall cycles, then forward from entry2.
      applyStimulus(1, 0, 0, 0, 0, 1, 7, OP_ALU, 1, 0, 0, 0);
      tick();
      applyStimulus(1, 1, 7, 0, 0, 0, 0, OP_ALU, 0, 0, 0, 0);
      checkOutput("mul_stall1", 32'(pc_en_o), 32'd0);
      tick();
      checkOutput("mul_stall2", 32'(pc_en_o), 32'd0);
      tick();
      checkOutput("mul_resume_pc_en", 32'(pc_en_o),     32'd1);
      checkOutput("mul_fwd_a",        32'(fwd_a_o),     32'd3);
      checkOutput("mul_stall_cnt",    32'(stall_cnt_o), 32'd3);
      tick();

      // Taken branch over a pending load-use: two flush cycles, no stall.
      applyStimulus(1, 0, 0, 0, 0, 1, 8, OP_LOAD, 0, 0, 0, 0);
      tick();
      applyStimulus(1, 1, 8, 0, 0, 0, 0, OP_ALU, 0, 0, 1, 0);
      checkOutput("br_fd_flush1", 32'(fd_flush_o), 32'd1);
      checkOutput("br_de_flush1", 32'(de_flush_o), 32'd1);
      checkOutput("br_pc_en1",    32'(pc_en_o),    32'd1);
      tick();
      applyStimulus(1, 1, 8, 0, 0, 0, 0, OP_ALU, 0, 0, 0, 0);
      checkOutput("br_fd_flush2", 32'(fd_flush_o), 32'd1);
      checkOutput("br_de_flush2", 32'(de_flush_o), 32'd1);
      tick();
      checkOutput("br_done_fd_flush", 32'(fd_flush_o),  32'd0);
      checkOutput("br_done_fwd_a",    32'(fwd_a_o),     32'd3);
      checkOutput("br_stall_cnt",     32'(stall_cnt_o), 32'd3);
      tick();

      // Memory freeze for 3 cycles during a load-use, then resume.
      applyStimulus(1, 0, 0, 0, 0, 1, 9, OP_LOAD, 0, 0, 0, 0);
      tick();
      applyStimulus(1, 1, 9, 0, 0, 0, 0, OP_ALU, 0, 0, 0, 1);
      checkOutput("ms_pc_en",    32'(pc_en_o),    32'd0);
      checkOutput("ms_de_en",    32'(de_en_o),    32'd0);
      checkOutput("ms_em_en",    32'(em_en_o),    32'd0);
      checkOutput("ms_mw_en",    32'(mw_en_o),    32'd0);
      checkOutput("ms_de_flush", 32'(de_flush_o), 32'd0);
      tick();
      tick();
      tick();
      checkOutput("ms_stall_cnt", 32'(stall_cnt_o), 32'd6);
      applyStimulus(1, 1, 9, 0, 0, 0, 0, OP_ALU, 0, 0, 0, 0);
      checkOutput("ms_resume_stall",    32'(pc_en_o),    32'd0);
      checkOutput("ms_resume_de_flush", 32'(de_flush_o), 32'd1);
      tick();
      checkOutput("ms_after_pc_en", 32'(pc_en_o),     32'd1);
      checkOutput("ms_after_fwd_a", 32'(fwd_a_o),     32'd2);
      checkOutput("ms_after_cnt",   32'(stall_cnt_o), 32'd7);
      tick();

      // LW x8 then SW with rs2=x8 as store data.
      applyStimulus(1, 0, 0, 0, 0, 1, 8, OP_LOAD, 0, 0, 0, 0);
      tick();
      applyStimulus(1, 0, 0, 1, 8, 0, 0, OP_NONE, 0, 1, 0, 0);
`ifdef HDU_LS_FWD_EN
      checkOutput("ls_pc_en",  32'(pc_en_o),  32'd1);
      checkOutput("ls_fwd_b",  32'(fwd_b_o),  32'd0);
      checkOutput("ls_fwd_ls", 32'(fwd_ls_o), 32'd0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, OP_NONE, 0, 0, 0, 0);
      checkOutput("ls_fwd_ls_pulse", 32'(fwd_ls_o),    32'd1);
      checkOutput("ls_stall_cnt",    32'(stall_cnt_o), 32'd7);
      tick();
      checkOutput("ls_fwd_ls_end", 32'(fwd_ls_o), 32'd0);
`else
      checkOutput("ls_pc_en",  32'(pc_en_o),  32'd0);
      checkOutput("ls_fwd_ls", 32'(fwd_ls_o), 32'd0);
      tick();
      checkOutput("ls_resume_pc_en", 32'(pc_en_o),     32'd1);
      checkOutput("ls_fwd_b",        32'(fwd_b_o),     32'd2);
      checkOutput("ls_stall_cnt",    32'(stall_cnt_o), 32'd8);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, OP_NONE, 0, 0, 0, 0);
      tick();
      checkOutput("ls_fwd_ls_end", 32'(fwd_ls_o), 32'd0);
`endif

      // x0 is never tracked, so reading it neither stalls nor forwards.
      applyStimulus(1, 0, 0, 0, 0, 1, 0, OP_LOAD, 0, 0, 0, 0);
      tick();
      applyStimulus(1, 1, 0, 1, 0, 0, 0, OP_ALU, 0, 0, 0, 0);
      checkOutput("x0_pc_en", 32'(pc_en_o), 32'd1);
      checkOutput("x0_fwd_a", 32'(fwd_a_o), 32'd0);
      checkOutput("x0_fwd_b", 32'(fwd_b_o), 32'd0);
      tick();

      // Reset asserted in the middle of a load-use stall, off the clock edge.
      applyStimulus(1, 0, 0, 0, 0, 1, 6, OP_LOAD, 0, 0, 0, 0);
      tick();
      applyStimulus(1, 0, 0, 1, 6, 0, 0, OP_ALU, 0, 0, 0, 0);
      checkOutput("prerst_pc_en", 32'(pc_en_o), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_pc_en",     32'(pc_en_o),     32'd1);
      checkOutput("midrst_fd_en",     32'(fd_en_o),     32'd1);
      checkOutput("midrst_de_flush",  32'(de_flush_o),  32'd0);
      checkOutput("midrst_stall_cnt", 32'(stall_cnt_o), 32'd0);
      checkOutput("midrst_fwd_b",     32'(fwd_b_o),     32'd0);
      #2;
      rst_n = 1'b1;
      tick();
      checkOutput("postrst_pc_en", 32'(pc_en_o),     32'd1);
      checkOutput("postrst_cnt",   32'(stall_cnt_o), 32'd0);

      // Long memory freeze drives the 4-bit counter into saturation.
      applyStimulus(0, 0, 0, 0, 0, 0, 0, OP_NONE, 0, 0, 0, 1);
      repeat (14) tick();
      checkOutput("cnt_14", 32'(stall_cnt_o), 32'd14);
      tick();
      checkOutput("cnt_15", 32'(stall_cnt_o), 32'd15);
      repeat (3) tick();
      checkOutput("cnt_saturate", 32'(stall_cnt_o), 32'd15);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, OP_NONE, 0, 0, 0, 0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
